// File: rtl/vc_buf_ctrl.sv
// vc_buf_ctrl: splits one external dual-port RAM into NUM_VC circular FIFOs,
// one per virtual channel, and streams flits out round-robin across the
// non-empty channels.
//
// Optional build macro: VC_CREDIT_RET_EN adds CREDIT_VALID / CREDIT_VC, a
// registered one-cycle pulse after every output handshake that returns a
// credit for that flit's VC.
//
// Handshake: a flit moves on the output when OUT_VALID && OUT_READY are both
// high at a rising CLK edge. OUT_VALID never drops, and OUT_DATA / OUT_VC never
// change, until that edge. On the input side, a flit is taken when IN_VALID &&
// IN_READY[IN_VC]. A flit offered to a full VC is dropped and sets OVF_ERR.
//
// The FSM state is kept in state_q (type state_e) so checkers can bind to it.
module vc_buf_ctrl #(
  parameter int WIDTH    = 8,
  parameter int NUM_VC   = 4,
  parameter int VC_DEPTH = 4
) (
  input  logic                                   CLK,
  input  logic                                   RSTn,
  input  logic                                   IN_VALID,
  input  logic [$clog2(NUM_VC)-1:0]              IN_VC,
  input  logic [WIDTH-1:0]                       IN_DATA,
  output logic [NUM_VC-1:0]                      IN_READY,
  output logic                                   OUT_VALID,
  input  logic                                   OUT_READY,
  output logic [WIDTH-1:0]                       OUT_DATA,
  output logic [$clog2(NUM_VC)-1:0]              OUT_VC,
  output logic [NUM_VC-1:0]                      VC_EMPTY,
  output logic                                   OVF_ERR,
  output logic                                   RAM_WR_EN,
  output logic [$clog2(NUM_VC)+$clog2(VC_DEPTH)-1:0] RAM_WR_ADDR,
  output logic [WIDTH-1:0]                       RAM_WR_DATA,
  output logic                                   RAM_RD_EN,
  output logic [$clog2(NUM_VC)+$clog2(VC_DEPTH)-1:0] RAM_RD_ADDR,
  input  logic [WIDTH-1:0]                       RAM_RD_DATA
`ifdef VC_CREDIT_RET_EN
  ,
  output logic                                   CREDIT_VALID,
  output logic [$clog2(NUM_VC)-1:0]              CREDIT_VC
`endif
);

  localparam int VC_W   = $clog2(NUM_VC);
  localparam int PTR_W  = $clog2(VC_DEPTH);
  localparam int ADDR_W = VC_W + PTR_W;
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]    wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]    rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]    rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0]    count_q  [NUM_VC];
  logic [CNT_W-1:0]    count_d  [NUM_VC];
  logic [VC_W-1:0]     rr_q, rr_d;
  logic [VC_W-1:0]     lat_vc_q, lat_vc_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [VC_W-1:0]     out_vc_q, out_vc_d;
  logic                ovf_q, ovf_d;

  logic                wr_acc;
  logic                any_ne;
  logic                issue;
  logic                grant_found;
  logic [VC_W-1:0]     grant;
  logic [VC_W-1:0]     scan_idx;
  logic [NUM_VC-1:0]   wr_hit;
  logic [NUM_VC-1:0]   rd_hit;

  // Per-VC status straight from the registered occupancy counts.
  always_comb begin
    IN_READY = '0;
    VC_EMPTY = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      IN_READY[v] = (count_q[v] != CNT_W'(VC_DEPTH));
      VC_EMPTY[v] = (count_q[v] == '0);
    end
  end

  // Round-robin pick: first non-empty VC strictly after the last grant.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    scan_idx    = '0;
    for (int i = 1; i <= NUM_VC; i++) begin
      scan_idx = rr_q + VC_W'(i);
      if (!grant_found && !VC_EMPTY[scan_idx]) begin
        grant       = scan_idx;
        grant_found = 1'b1;
      end
    end
  end

  assign any_ne = ~&VC_EMPTY;
  assign wr_acc = IN_VALID && IN_READY[IN_VC];

  // FSM next state; decides when a RAM read is issued.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_ne) begin
          issue   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (OUT_READY) begin
          if (any_ne) begin
            issue   = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM strobes and addresses; written slots only become readable next cycle.
  always_comb begin
    RAM_WR_EN   = wr_acc;
    RAM_WR_ADDR = {IN_VC, wr_ptr_q[IN_VC]};
    RAM_WR_DATA = IN_DATA;
    RAM_RD_EN   = issue;
    RAM_RD_ADDR = {grant, rd_ptr_q[grant]};
  end

  // Pointer and count updates; a write and issue on one VC cancel in count.
  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_hit[v]   = wr_acc && (IN_VC == VC_W'(v));
      rd_hit[v]   = issue && (grant == VC_W'(v));
      wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(wr_hit[v]);
      rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(rd_hit[v]);
      count_d[v]  = count_q[v] + CNT_W'(wr_hit[v]) - CNT_W'(rd_hit[v]);
    end
  end

  // Arbitration memory, output register capture and the sticky overflow flag.
  always_comb begin
    rr_d       = issue ? grant : rr_q;
    lat_vc_d   = issue ? grant : lat_vc_q;
    out_data_d = out_data_q;
    out_vc_d   = out_vc_q;
    if (state_q == ST_WAIT) begin
      out_data_d = RAM_RD_DATA;
      out_vc_d   = lat_vc_q;
    end
    ovf_d = ovf_q | (IN_VALID && !IN_READY[IN_VC]);
  end

  // Registered state; reset discards every queued or in-flight flit.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      rr_q       <= VC_W'(NUM_VC - 1);
      lat_vc_q   <= '0;
      out_data_q <= '0;
      out_vc_q   <= '0;
      ovf_q      <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lat_vc_q   <= lat_vc_d;
      out_data_q <= out_data_d;
      out_vc_q   <= out_vc_d;
      ovf_q      <= ovf_d;
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        count_q[v]  <= count_d[v];
      end
    end
  end

  assign OUT_VALID = (state_q == ST_HOLD);
  assign OUT_DATA  = out_data_q;
  assign OUT_VC    = out_vc_q;
  assign OVF_ERR   = ovf_q;

`ifdef VC_CREDIT_RET_EN
  logic            credit_valid_q, credit_valid_d;
  logic [VC_W-1:0] credit_vc_q, credit_vc_d;

  // One credit pulse per completed output handshake, tagged with its VC.
  always_comb begin
    credit_valid_d = OUT_VALID && OUT_READY;
    credit_vc_d    = (OUT_VALID && OUT_READY) ? out_vc_q : '0;
  end

  // Credit return register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
    end else begin
      credit_valid_q <= credit_valid_d;
      credit_vc_q    <= credit_vc_d;
    end
  end

  assign CREDIT_VALID = credit_valid_q;
  assign CREDIT_VC    = credit_vc_q;
`endif

endmodule

// File: tb/tb_vc_buf_ctrl.sv
// Bench for vc_buf_ctrl: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model of the buffers.
module tb_vc_buf_ctrl;

  localparam int WIDTH  = 8;
  localparam int NUM_VC = 4;
  localparam int DEPTH  = 4;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        IN_VALID;
  logic [1:0]  IN_VC;
  logic [7:0]  IN_DATA;
  logic [3:0]  IN_READY;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [7:0]  OUT_DATA;
  logic [1:0]  OUT_VC;
  logic [3:0]  VC_EMPTY;
  logic        OVF_ERR;
  logic        RAM_WR_EN;
  logic [3:0]  RAM_WR_ADDR;
  logic [7:0]  RAM_WR_DATA;
  logic        RAM_RD_EN;
  logic [3:0]  RAM_RD_ADDR;
  logic [7:0]  RAM_RD_DATA;
`ifdef VC_CREDIT_RET_EN
  logic        CREDIT_VALID;
  logic [1:0]  CREDIT_VC;
`endif

  vc_buf_ctrl #(.WIDTH(WIDTH), .NUM_VC(NUM_VC), .VC_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .IN_VALID(IN_VALID), .IN_VC(IN_VC), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_VC(OUT_VC),
    .VC_EMPTY(VC_EMPTY), .OVF_ERR(OVF_ERR),
    .RAM_WR_EN(RAM_WR_EN), .RAM_WR_ADDR(RAM_WR_ADDR), .RAM_WR_DATA(RAM_WR_DATA),
    .RAM_RD_EN(RAM_RD_EN), .RAM_RD_ADDR(RAM_RD_ADDR), .RAM_RD_DATA(RAM_RD_DATA)
`ifdef VC_CREDIT_RET_EN
    , .CREDIT_VALID(CREDIT_VALID), .CREDIT_VC(CREDIT_VC)
`endif
  );

  // ---------------- clock / reset / attached RAM ----------------
  always #5 CLK = ~CLK;

  logic [7:0] mem [16];
  always @(posedge CLK) begin
    if (RAM_WR_EN) mem[RAM_WR_ADDR] <= RAM_WR_DATA;
    if (RAM_RD_EN) RAM_RD_DATA <= mem[RAM_RD_ADDR];
  end

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] exp_q [NUM_VC][$];   // flits stored per VC, not yet issued
  int         wr_tot [NUM_VC];           // total accepted writes per VC
  int         rd_tot [NUM_VC];           // total issues per VC
  int         m_rr;                      // last granted VC
  int         m_ph;                      // 0 nothing held, 1 read in flight, 2 presenting
  logic [7:0] m_pend_data;
  int         m_pend_vc;
  logic [7:0] m_out_data;
  int         m_out_vc;
  bit         m_ovf;
  bit         m_cred_v;
  int         m_cred_vc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NUM_VC; v++) begin
      exp_q[v].delete();
      wr_tot[v] = 0;
      rd_tot[v] = 0;
    end
    m_rr = NUM_VC - 1;
    m_ph = 0;
    m_pend_data = '0;
    m_pend_vc = 0;
    m_out_data = '0;
    m_out_vc = 0;
    m_ovf = 0;
    m_cred_v = 0;
    m_cred_vc = 0;
  endtask

  // Asserts reset at the current time and checks the cleared outputs.
  task automatic apply_reset();
    IN_VALID = 1'b0;
    RSTn = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_out_data", 32'(OUT_DATA), 32'd0);
    check("rst_out_vc", 32'(OUT_VC), 32'd0);
    check("rst_in_ready", 32'(IN_READY), 32'hF);
    check("rst_vc_empty", 32'(VC_EMPTY), 32'hF);
    check("rst_ovf", 32'(OVF_ERR), 32'd0);
    check("rst_wr_en", 32'(RAM_WR_EN), 32'd0);
    check("rst_rd_en", 32'(RAM_RD_EN), 32'd0);
`ifdef VC_CREDIT_RET_EN
    check("rst_credit_valid", 32'(CREDIT_VALID), 32'd0);
`endif
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit iv, input int ivc, input logic [7:0] idat, input bit ordy);
    bit   wr, issue;
    int   g;
    logic [3:0] exp_rdy, exp_emp;
    @(negedge CLK);
    IN_VALID  = iv;
    IN_VC     = 2'(ivc);
    IN_DATA   = idat;
    OUT_READY = ordy;
    #1;
    // expected combinational view of the current cycle
    exp_rdy = '0;
    exp_emp = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      exp_rdy[v] = (exp_q[v].size() != DEPTH);
      exp_emp[v] = (exp_q[v].size() == 0);
    end
    wr = iv && (exp_q[ivc].size() != DEPTH);
    g = -1;
    for (int i = 1; i <= NUM_VC; i++) begin
      int v = (m_rr + i) % NUM_VC;
      if (g < 0 && exp_q[v].size() != 0) g = v;
    end
    issue = (g >= 0) && (m_ph == 0 || (m_ph == 2 && ordy));

    check("in_ready", 32'(IN_READY), 32'(exp_rdy));
    check("vc_empty", 32'(VC_EMPTY), 32'(exp_emp));
    check("out_valid", 32'(OUT_VALID), 32'(m_ph == 2));
    check("out_data", 32'(OUT_DATA), 32'(m_out_data));
    check("out_vc", 32'(OUT_VC), 32'(m_out_vc));
    check("ovf_err", 32'(OVF_ERR), 32'(m_ovf));
    check("ram_wr_en", 32'(RAM_WR_EN), 32'(wr));
    if (wr) begin
      check("ram_wr_addr", 32'(RAM_WR_ADDR), 32'(ivc * DEPTH + wr_tot[ivc] % DEPTH));
      check("ram_wr_data", 32'(RAM_WR_DATA), 32'(idat));
    end
    check("ram_rd_en", 32'(RAM_RD_EN), 32'(issue));
    if (issue)
      check("ram_rd_addr", 32'(RAM_RD_ADDR), 32'(g * DEPTH + rd_tot[g] % DEPTH));
`ifdef VC_CREDIT_RET_EN
    check("credit_valid", 32'(CREDIT_VALID), 32'(m_cred_v));
    if (m_cred_v) check("credit_vc", 32'(CREDIT_VC), 32'(m_cred_vc));
`endif

    // advance the model across the coming rising edge
    m_cred_v  = (m_ph == 2) && ordy;
    m_cred_vc = m_out_vc;
    if (iv && !wr) m_ovf = 1;
    if (m_ph == 1) begin
      m_out_data = m_pend_data;
      m_out_vc   = m_pend_vc;
      m_ph       = 2;
    end else if (issue) begin
      m_pend_data = exp_q[g].pop_front();
      m_pend_vc   = g;
      m_rr        = g;
      rd_tot[g]++;
      m_ph        = 1;
    end else if (m_ph == 2 && ordy) begin
      m_ph = 0;
    end
    if (wr) begin
      exp_q[ivc].push_back(idat);
      wr_tot[ivc]++;
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, ordy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    IN_VALID = 0; IN_VC = 0; IN_DATA = 0; OUT_READY = 0; RSTn = 1;
    #2;
    apply_reset();

    // single flit into VC2 (write address 8), then drain
    step(1, 2, 8'hA1, 0);
    idle(4, 1);

    // fill VC1 past full with the output stalled, then drain in order
    for (int i = 0; i < 6; i++) step(1, 1, 8'(8'h10 + i), 0);
    idle(12, 1);

    // one flit per VC, then round-robin drain with reloads of VC0 and VC3
    for (int v = 0; v < NUM_VC; v++) step(1, v, 8'(v * 8'h11), 0);
    idle(6, 1);
    step(1, 0, 8'h40, 1);
    step(1, 3, 8'h43, 1);
    idle(10, 1);

    // six flits to VC0 interleaved with reads: pointer wrap
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 8'(8'h60 + i), 1);
      step(0, 0, 8'h00, 0);
    end
    idle(14, 1);

    // concurrent write and issue on VC1 while it holds two flits
    step(1, 1, 8'h71, 0);
    step(1, 1, 8'h72, 0);
    step(1, 1, 8'h73, 0);
    step(1, 1, 8'h74, 1);
    idle(12, 1);

    // random traffic with alternating downstream back-pressure
    for (int blk = 0; blk < 16; blk++) begin
      int pr = (blk % 2) ? 90 : 25;
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 99) < 60, $urandom_range(0, NUM_VC - 1),
             8'($urandom_range(0, 255)), $urandom_range(0, 99) < pr);
    end
    idle(20, 1);

    // reset while a read is in flight: nothing may surface afterwards
    step(1, 2, 8'hA5, 1);
    step(0, 0, 8'h00, 1);
    @(posedge CLK);
    #2;
    apply_reset();
    idle(8, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
